// File: rtl/uart_nibble_loader_pkg.sv
// Shared definitions for the UART nibble loader: FSM state encoding and default frame header.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_nibble_loader_pkg;

  typedef enum logic [2:0] {
    stIDLE    = 3'd0,
    stLEN     = 3'd1,
    stPAYLOAD = 3'd2,
    stWR_LO   = 3'd3,
    stWR_HI   = 3'd4,
    stCHECK   = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_nibble_loader_if.sv
// Byte stream in from the UART receiver plus the instruction-memory write port out.
// Latency: n/a (wires only).
// Backpressure: none; the receiver strobes bytes and the memory always accepts writes.
// Ports:
//   rx_data_i / rx_valid_strb_i : received byte and its one-cycle strobe
//   mem_we_o / mem_addr_o / mem_wdata_o : nibble write port
// master = UART/memory side, slave = loader.
interface uart_nibble_loader_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NIBBLE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5
);
  logic [DATA_WIDTH-1:0]   rx_data_i;
  logic                    rx_valid_strb_i;
  logic                    mem_we_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic [NIBBLE_WIDTH-1:0] mem_wdata_o;

  modport master (
    output rx_data_i, rx_valid_strb_i,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  rx_data_i, rx_valid_strb_i,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/uart_nibble_loader_timeout_counter.sv
// Idle-gap watchdog: counts enabled cycles since the last clear, flags TIMEOUT_CYCLES-1.
// Latency: expired_o is decoded from the registered count (no input-to-output path).
// Backpressure: none; the count saturates at the expiry value until cleared.
// Ports: clk_i, reset_ni, clear_i (synchronous clear, wins), enable_i (count), expired_o.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES   = 65535,
  parameter int TIMEOUT_BITWIDTH = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TIMEOUT_BITWIDTH-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_nibble_loader.sv
// Loads a SYNC/LEN/payload/XOR-checksum frame into instruction memory, two nibbles per byte.
// Latency: payload strobe at t -> low-nibble write at t+1, high at t+2; CHK strobe -> status at t+1.
// Backpressure: none; a byte arriving during a nibble write aborts the frame after that write.
// Ports: clk_i, reset_ni, bus (rx byte in, nibble write out), cpu_hold_o, busy_o,
//        load_done_o (sticky success), load_error_o (sticky abort).
module uart_nibble_loader
  import uart_nibble_loader_pkg::*;
#(
  parameter int              DATA_WIDTH       = 8,
  parameter int              NIBBLE_WIDTH     = 4,
  parameter int              ADDR_WIDTH       = 5,
  parameter logic [7:0]      SYNC_BYTE        = SYNC_BYTE_DEFAULT,
  parameter int              TIMEOUT_CYCLES   = 65535,
  parameter int              TIMEOUT_BITWIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  uart_nibble_loader_if.slave   bus,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  localparam int MAX_LEN = 2 ** (ADDR_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;    // next nibble address
  logic [ADDR_WIDTH-1:0]   rem_q, rem_d;        // payload bytes still to come
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;        // running XOR of payload
  logic [DATA_WIDTH-1:0]   byte_q, byte_d;      // payload byte being written
  logic                    overrun_q, overrun_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NIBBLE_WIDTH-1:0] wdata_q, wdata_d;
  logic                    hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    strb;
  logic [DATA_WIDTH-1:0]   rx;
  logic                    tmo_en;
  logic                    tmo_expired;
  logic                    abort;

  assign strb   = bus.rx_valid_strb_i;
  assign rx     = bus.rx_data_i;
  // Only the states that wait on the receiver are watched.
  assign tmo_en = (state_q == stLEN) || (state_q == stPAYLOAD) || (state_q == stCHECK);

  loader_timeout_counter #(
    .TIMEOUT_CYCLES   (TIMEOUT_CYCLES),
    .TIMEOUT_BITWIDTH (TIMEOUT_BITWIDTH)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (strb || !tmo_en),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    byte_d    = byte_q;
    overrun_d = overrun_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    abort     = 1'b0;

    case (state_q)
      stIDLE: begin
        if (strb && rx == SYNC_BYTE) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          hold_d    = 1'b1;
          waddr_d   = '0;
          acc_d     = '0;
          overrun_d = 1'b0;
          state_d   = stLEN;
        end
      end
      stLEN: begin
        if (strb) begin
          if (rx == '0 || rx > DATA_WIDTH'(MAX_LEN)) begin
            abort = 1'b1;
          end else begin
            rem_d   = rx[ADDR_WIDTH-1:0];
            state_d = stPAYLOAD;
          end
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      stPAYLOAD: begin
        if (strb) begin
          // The low-nibble write is registered here so it is on the port during stWR_LO.
          byte_d  = rx;
          acc_d   = acc_q ^ rx;
          we_d    = 1'b1;
          addr_d  = waddr_q;
          wdata_d = rx[NIBBLE_WIDTH-1:0];
          waddr_d = waddr_q + 1'b1;
          state_d = stWR_LO;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      stWR_LO: begin
        we_d    = 1'b1;
        addr_d  = waddr_q;
        wdata_d = byte_q[DATA_WIDTH-1:NIBBLE_WIDTH];
        waddr_d = waddr_q + 1'b1;
        state_d = stWR_HI;
        if (strb) overrun_d = 1'b1;
      end
      stWR_HI: begin
        // High nibble is on the port this cycle; an overrun aborts only after it lands.
        rem_d = rem_q - 1'b1;
        if (overrun_q || strb) begin
          abort = 1'b1;
        end else if (rem_q == ADDR_WIDTH'(1)) begin
          state_d = stCHECK;
        end else begin
          state_d = stPAYLOAD;
        end
      end
      stCHECK: begin
        if (strb) begin
          if (rx == acc_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = stIDLE;
          end else begin
            abort = 1'b1;
          end
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      default: state_d = stIDLE;
    endcase

    if (abort) begin
      err_d   = 1'b1;
      hold_d  = 1'b1;
      state_d = stIDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= stIDLE;
      waddr_q   <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      byte_q    <= '0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      byte_q    <= byte_d;
      overrun_q <= overrun_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign cpu_hold_o      = hold_q;
  assign busy_o          = (state_q != stIDLE);
  assign load_done_o     = done_q;
  assign load_error_o    = err_q;

endmodule
